rs_trig_sched: RTL and testbench

- Round-robin scheduler that shares one clocked RS trigger between N_REQ requesters.
- Converts each requester's set/clear request into a clean, width-controlled S or R pulse.
- Guarantees S=R=1 is never driven, inserts a guard gap between commands, and checks the trigger's Q/Qn feedback against the expected state.
- Sits between control logic and the RS trigger's S/R inputs.

---
 rtl/rs_trig_sched.sv | 203 ++++++++++++++++++++
 tb/tb_rs_trig_sched.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/rs_trig_sched.sv
// ----------------------------------------------------------------------------
// rs_trig_sched
//
// Round-robin scheduler that lets N_REQ requesters share one clocked RS
// trigger. A granted set/clear request becomes a clean S or R pulse of
// PULSE_W cycles. The pulse is followed by GAP_W cycles with S=R=0 and then
// a one-cycle CHECK of the trigger's Q/Qn feedback against the expected
// state. S and R are never high together.
//
// Parameters:
//   N_REQ    number of requesters (2..8)
//   PULSE_W  S/R pulse width in clk cycles (1..15)
//   GAP_W    idle cycles with S=R=0 after each pulse (1..15)
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous reset, active low
//   set_req   per-requester set request, held until granted
//   clr_req   per-requester clear request, held until granted
//   err_clr   synchronous clear of err
//   grant     one-hot, 1-cycle pulse to the accepted requester
//   s_out     S drive to the RS trigger
//   r_out     R drive to the RS trigger
//   q_fb      trigger Q feedback
//   qn_fb     trigger Qn feedback
//   busy      high in any state except IDLE
//   q_exp     expected trigger state
//   conflict  1-cycle pulse: a requester had set and clear high in IDLE
//   err       sticky feedback mismatch flag
//
// Optional feature (macro RS_SKIP_REDUNDANT_EN):
//   When defined, a request that already matches q_exp is granted but
//   issues no pulse, and the FSM stays in IDLE.
// ----------------------------------------------------------------------------
module rs_trig_sched #(
    parameter int N_REQ   = 4,
    parameter int PULSE_W = 2,
    parameter int GAP_W   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] set_req,
    input  logic [N_REQ-1:0] clr_req,
    input  logic             err_clr,
    output logic [N_REQ-1:0] grant,
    output logic             s_out,
    output logic             r_out,
    input  logic             q_fb,
    input  logic             qn_fb,
    output logic             busy,
    output logic             q_exp,
    output logic             conflict,
    output logic             err
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2,
        CHECK = 2'd3
    } state_t;

    state_t state, next_state;

    logic [3:0]       cnt, cnt_d;
    logic [PTR_W-1:0] ptr, ptr_d;
    logic [PTR_W-1:0] cand, sel_idx;
    logic [N_REQ-1:0] eligible;
    logic             found, sel_set;
    logic             start, launch, redundant;
    logic             cmd_set, cmd_set_d;
    logic             mismatch;

    logic [N_REQ-1:0] grant_d;
    logic             s_d, r_d, busy_d, q_exp_d, conflict_d, err_d;

    // A requester raising both set and clear is ambiguous and is skipped.
    assign eligible = set_req ^ clr_req;

    // Round-robin search: the first eligible requester at or after ptr wins.
    always_comb begin
        found   = 1'b0;
        sel_idx = '0;
        sel_set = 1'b0;
        cand    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = PTR_W'((int'(ptr) + k) % N_REQ);
            if (!found && eligible[cand]) begin
                found   = 1'b1;
                sel_idx = cand;
                sel_set = set_req[cand];
            end
        end
    end

`ifdef RS_SKIP_REDUNDANT_EN
    // A command that would not change the trigger is acknowledged only.
    assign redundant = (sel_set == q_exp);
`else
    assign redundant = 1'b0;
`endif

    assign start  = (state == IDLE) && found;
    assign launch = start && !redundant;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; cnt counts cycles spent inside PULSE and GAP.
    always_comb begin
        next_state = state;
        cnt_d      = cnt;
        case (state)
            IDLE: begin
                if (launch) begin
                    next_state = PULSE;
                    cnt_d      = '0;
                end
            end
            PULSE: begin
                if (cnt == 4'(PULSE_W - 1)) begin
                    next_state = GAP;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt + 4'd1;
                end
            end
            GAP: begin
                if (cnt == 4'(GAP_W - 1)) begin
                    next_state = CHECK;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt + 4'd1;
                end
            end
            CHECK: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Output logic computes next-cycle values so every output is a flop.
    // S/R are derived from next_state, so both can only be high in PULSE,
    // and cmd_set picks exactly one of them.
    always_comb begin
        grant_d = '0;
        if (start) begin
            grant_d[sel_idx] = 1'b1;
        end
        cmd_set_d  = launch ? sel_set : cmd_set;
        s_d        = (next_state == PULSE) && cmd_set_d;
        r_d        = (next_state == PULSE) && !cmd_set_d;
        busy_d     = (next_state != IDLE);
        q_exp_d    = launch ? sel_set : q_exp;
        ptr_d      = ptr;
        if (start) begin
            ptr_d = (sel_idx == PTR_W'(N_REQ - 1)) ? '0 : sel_idx + 1'b1;
        end
        conflict_d = (state == IDLE) && (|(set_req & clr_req));
        mismatch   = (state == CHECK) && ((q_fb != q_exp) || (qn_fb != ~q_exp));
        // A mismatch in the same cycle as err_clr must not be lost.
        err_d      = mismatch ? 1'b1 : (err_clr ? 1'b0 : err);
    end

    // Output and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant    <= '0;
            s_out    <= 1'b0;
            r_out    <= 1'b0;
            busy     <= 1'b0;
            q_exp    <= 1'b0;
            conflict <= 1'b0;
            err      <= 1'b0;
            ptr      <= '0;
            cnt      <= '0;
            cmd_set  <= 1'b0;
        end else begin
            grant    <= grant_d;
            s_out    <= s_d;
            r_out    <= r_d;
            busy     <= busy_d;
            q_exp    <= q_exp_d;
            conflict <= conflict_d;
            err      <= err_d;
            ptr      <= ptr_d;
            cnt      <= cnt_d;
            cmd_set  <= cmd_set_d;
        end
    end

endmodule

// File: tb/tb_rs_trig_sched.sv
// ----------------------------------------------------------------------------
// tb_rs_trig_sched
//
// Directed testbench for rs_trig_sched with default parameters. A small
// RS trigger model supplies Q/Qn feedback; it can be overridden to create
// a feedback fault. Inputs change and outputs are sampled on the falling
// clock edge. Define RS_SKIP_REDUNDANT_EN to also exercise the skip feature.
// ----------------------------------------------------------------------------
module tb_rs_trig_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] set_req, clr_req, grant;
    logic       err_clr, s_out, r_out, q_fb, qn_fb;
    logic       busy, q_exp, conflict, err;

    logic       q_model = 1'b0;
    logic       force_en = 1'b0;
    logic       force_val = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    rs_trig_sched #(.N_REQ(4), .PULSE_W(2), .GAP_W(1)) dut (
        .clk(clk), .rst_n(rst_n), .set_req(set_req), .clr_req(clr_req),
        .err_clr(err_clr), .grant(grant), .s_out(s_out), .r_out(r_out),
        .q_fb(q_fb), .qn_fb(qn_fb), .busy(busy), .q_exp(q_exp),
        .conflict(conflict), .err(err)
    );

    always #5 clk = ~clk;

    // The trigger itself is not reset by the scheduler's reset.
    always @(posedge clk) begin
        if (s_out) q_model <= 1'b1;
        else if (r_out) q_model <= 1'b0;
    end

    assign q_fb  = force_en ? force_val : q_model;
    assign qn_fb = ~q_fb;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; set_req = '0; clr_req = '0; err_clr = 1'b0;
        step();
        vectors++; if (grant !== 4'b0000) begin miscompares++; $display("[TB] FAIL reset_grant got %b want 0000", grant); end
        vectors++; if (s_out !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_s got %b want 0", s_out); end
        vectors++; if (r_out !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_r got %b want 0", r_out); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        vectors++; if (q_exp !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_qexp got %b want 0", q_exp); end
        vectors++; if (conflict !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_conflict got %b want 0", conflict); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_err got %b want 0", err); end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_set();
        logic [3:0] exp_grant;
        logic       exp_s, exp_busy;
        set_req = 4'b0001;
        step();
        for (int c = 0; c < 5; c++) begin
            exp_grant = (c == 0) ? 4'b0001 : 4'b0000;
            exp_s     = (c < 2);
            exp_busy  = (c < 4);
            vectors++; if (grant !== exp_grant) begin miscompares++; $display("[TB] FAIL single_grant c%0d got %b want %b", c, grant, exp_grant); end
            vectors++; if (s_out !== exp_s) begin miscompares++; $display("[TB] FAIL single_s c%0d got %b want %b", c, s_out, exp_s); end
            vectors++; if (r_out !== 1'b0) begin miscompares++; $display("[TB] FAIL single_r c%0d got %b want 0", c, r_out); end
            vectors++; if (busy !== exp_busy) begin miscompares++; $display("[TB] FAIL single_busy c%0d got %b want %b", c, busy, exp_busy); end
            if (c == 0) begin
                vectors++; if (q_exp !== 1'b1) begin miscompares++; $display("[TB] FAIL single_qexp got %b want 1", q_exp); end
                set_req = '0;
            end
            step();
        end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL single_err got %b want 0", err); end
    endtask

    task automatic test_contention();
        int         gcount;
        int         gcyc[3];
        logic [3:0] gval[3];
        logic       gs[3];
        logic       gr[3];
        logic       overlap;
        logic [3:0] exp_val[3];
        logic       exp_set[3];
        exp_val[0] = 4'b0010; exp_val[1] = 4'b0100; exp_val[2] = 4'b1000;
        exp_set[0] = 1'b1;    exp_set[1] = 1'b0;    exp_set[2] = 1'b1;
        // Restart from pointer 0 and q_exp 0 so no grant is redundant.
        rst_n = 1'b0; step(); rst_n = 1'b1; step();
        gcount = 0; overlap = 1'b0;
        set_req = 4'b1010; clr_req = 4'b0100;
        for (int c = 1; c <= 16; c++) begin
            step();
            if (s_out && r_out) overlap = 1'b1;
            if (grant != 4'b0000) begin
                if (gcount < 3) begin
                    gcyc[gcount] = c; gval[gcount] = grant;
                    gs[gcount] = s_out; gr[gcount] = r_out;
                end
                gcount++;
                set_req = set_req & ~grant;
                clr_req = clr_req & ~grant;
            end
        end
        vectors++; if (gcount != 3) begin miscompares++; $display("[TB] FAIL cont_count got %0d want 3", gcount); end
        for (int k = 0; k < 3; k++) begin
            if (k < gcount) begin
                vectors++; if (gval[k] !== exp_val[k]) begin miscompares++; $display("[TB] FAIL cont_grant%0d got %b want %b", k, gval[k], exp_val[k]); end
                vectors++; if (gcyc[k] != 1 + 5 * k) begin miscompares++; $display("[TB] FAIL cont_cycle%0d got %0d want %0d", k, gcyc[k], 1 + 5 * k); end
                vectors++; if (gs[k] !== exp_set[k] || gr[k] !== !exp_set[k]) begin miscompares++; $display("[TB] FAIL cont_pulse%0d got s=%b r=%b want s=%b", k, gs[k], gr[k], exp_set[k]); end
            end
        end
        vectors++; if (overlap !== 1'b0) begin miscompares++; $display("[TB] FAIL cont_overlap got %b want 0", overlap); end
    endtask

    task automatic test_conflict();
        set_req = 4'b0001; clr_req = 4'b0001;
        step();
        vectors++; if (conflict !== 1'b1) begin miscompares++; $display("[TB] FAIL conflict_pulse got %b want 1", conflict); end
        vectors++; if (grant !== 4'b0000) begin miscompares++; $display("[TB] FAIL conflict_grant got %b want 0000", grant); end
        vectors++; if (s_out !== 1'b0 || r_out !== 1'b0) begin miscompares++; $display("[TB] FAIL conflict_sr got s=%b r=%b want 0 0", s_out, r_out); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL conflict_busy got %b want 0", busy); end
        vectors++; if (q_exp !== 1'b1) begin miscompares++; $display("[TB] FAIL conflict_qexp got %b want 1", q_exp); end
        set_req = '0; clr_req = '0;
        step();
        vectors++; if (conflict !== 1'b0) begin miscompares++; $display("[TB] FAIL conflict_end got %b want 0", conflict); end
    endtask

    task automatic test_feedback_fault();
        force_en = 1'b1; force_val = 1'b1;
        clr_req = 4'b0010;
        step();
        vectors++; if (grant !== 4'b0010) begin miscompares++; $display("[TB] FAIL fault_grant got %b want 0010", grant); end
        vectors++; if (r_out !== 1'b1 || s_out !== 1'b0) begin miscompares++; $display("[TB] FAIL fault_r got s=%b r=%b want 0 1", s_out, r_out); end
        clr_req = '0;
        for (int c = 1; c < 5; c++) step();
        vectors++; if (err !== 1'b1) begin miscompares++; $display("[TB] FAIL fault_err_set got %b want 1", err); end
        step();
        vectors++; if (err !== 1'b1) begin miscompares++; $display("[TB] FAIL fault_err_sticky got %b want 1", err); end
        force_en = 1'b0;
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        vectors++; if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL fault_err_clr got %b want 0", err); end
    endtask

    task automatic test_reset_mid_pulse();
        set_req = 4'b0100;
        step();
        vectors++; if (grant !== 4'b0100 || s_out !== 1'b1) begin miscompares++; $display("[TB] FAIL midrst_start got g=%b s=%b want 0100 1", grant, s_out); end
        set_req = '0;
        step();
        vectors++; if (s_out !== 1'b1) begin miscompares++; $display("[TB] FAIL midrst_pulse2 got %b want 1", s_out); end
        rst_n = 1'b0;
        #1;
        vectors++; if (s_out !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_s got %b want 0", s_out); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_busy got %b want 0", busy); end
        vectors++; if (q_exp !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_qexp got %b want 0", q_exp); end
        step();
        rst_n = 1'b1;
        step();
        set_req = 4'b0001;
        step();
        vectors++; if (grant !== 4'b0001 || s_out !== 1'b1) begin miscompares++; $display("[TB] FAIL midrst_serve got g=%b s=%b want 0001 1", grant, s_out); end
        set_req = '0;
        for (int c = 1; c < 5; c++) step();
        vectors++; if (busy !== 1'b0 || err !== 1'b0 || q_exp !== 1'b1) begin miscompares++; $display("[TB] FAIL midrst_done got busy=%b err=%b qexp=%b want 0 0 1", busy, err, q_exp); end
    endtask

    task automatic test_err_set_wins();
        err_clr = 1'b1;
        force_en = 1'b1; force_val = 1'b1;
        clr_req = 4'b0010;
        step();
        vectors++; if (grant !== 4'b0010 || r_out !== 1'b1) begin miscompares++; $display("[TB] FAIL setwins_start got g=%b r=%b want 0010 1", grant, r_out); end
        clr_req = '0;
        for (int c = 1; c < 4; c++) step();
        vectors++; if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL setwins_pre got %b want 0", err); end
        step();
        vectors++; if (err !== 1'b1) begin miscompares++; $display("[TB] FAIL setwins_err got %b want 1", err); end
        step();
        vectors++; if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL setwins_clr got %b want 0", err); end
        err_clr = 1'b0;
        force_en = 1'b0;
    endtask

`ifdef RS_SKIP_REDUNDANT_EN
    task automatic test_skip_redundant();
        set_req = 4'b1000;
        step();
        vectors++; if (grant !== 4'b1000 || s_out !== 1'b1) begin miscompares++; $display("[TB] FAIL skip_prep got g=%b s=%b want 1000 1", grant, s_out); end
        set_req = '0;
        for (int c = 1; c < 5; c++) step();
        set_req = 4'b0100;
        step();
        vectors++; if (grant !== 4'b0100) begin miscompares++; $display("[TB] FAIL skip_grant got %b want 0100", grant); end
        vectors++; if (s_out !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("[TB] FAIL skip_nopulse got s=%b busy=%b want 0 0", s_out, busy); end
        set_req = '0;
        step();
        vectors++; if (grant !== 4'b0000 || s_out !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("[TB] FAIL skip_after got g=%b s=%b busy=%b want 0000 0 0", grant, s_out, busy); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_set();
        test_contention();
        test_conflict();
        test_feedback_fault();
        test_reset_mid_pulse();
        test_err_set_wins();
`ifdef RS_SKIP_REDUNDANT_EN
        test_skip_redundant();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
